// File: rtl/layer0_leakyrelu_rx.sv
// layer0_leakyrelu_rx: captures one frame of 64-bit beats into a byte buffer, throttling
// ready by a rotating pattern and flagging framing errors and mid-frame stalls.
module layer0_leakyrelu_rx #(
  parameter int INDEX_END = 32,
  parameter logic [7:0] READY_PATTERN = 8'hFF,
  parameter int TIMEOUT = 64
) (
  input  logic        sclk,
  input  logic        s_rst_n,
  input  logic [63:0] leakyrelu_data,
  input  logic        leakyrelu_valid,
  input  logic        leakyrelu_last,
  output logic        ready,
  input  logic        clr,
  input  logic [7:0]  rd_addr,
  output logic [7:0]  rd_data,
  output logic        frame_done,
  output logic        err_early_last,
  output logic        err_missing_last,
  output logic        err_timeout,
  output logic [5:0]  beat_cnt
);
  localparam int DEPTH = INDEX_END * 8;
  localparam int AW = $clog2(DEPTH);
  typedef enum logic {RECV, DONE} state_t;
  state_t state_q, state_d;
  logic [2:0] phase_q, phase_d;
  logic [5:0] beat_cnt_q, beat_cnt_d;
  logic [7:0] idle_q, idle_d;
  logic ready_q, ready_d;
  logic frame_done_q, frame_done_d;
  logic early_q, early_d;
  logic missing_q, missing_d;
  logic timeout_q, timeout_d;
  logic [7:0] rd_data_q;
  logic [7:0] mem [DEPTH];
  logic take, at_end;
  // ready is only ever high in RECV, so ready_q alone qualifies acceptance
  assign take = leakyrelu_valid && ready_q && !clr;
  assign at_end = beat_cnt_q == 6'(INDEX_END - 1);
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    beat_cnt_d = beat_cnt_q;
    idle_d = idle_q;
    frame_done_d = frame_done_q;
    early_d = early_q;
    missing_d = missing_q;
    timeout_d = timeout_q;
    if (clr) begin
      state_d = RECV;
      phase_d = '0;
      beat_cnt_d = '0;
      idle_d = '0;
      frame_done_d = 1'b0;
      early_d = 1'b0;
      missing_d = 1'b0;
      timeout_d = 1'b0;
    end else if (state_q == RECV) begin
      phase_d = phase_q + 3'd1;
      if (take) begin
        beat_cnt_d = beat_cnt_q + 6'd1;
        idle_d = '0;
        frame_done_d = leakyrelu_last && at_end;
        early_d = leakyrelu_last && !at_end;
        missing_d = !leakyrelu_last && at_end;
        state_d = (leakyrelu_last || at_end) ? DONE : RECV;
      end else if (beat_cnt_q != '0) begin
        idle_d = idle_q + 8'd1;
        timeout_d = idle_d == 8'(TIMEOUT);
        state_d = timeout_d ? DONE : RECV;
      end
    end
    ready_d = (state_d == RECV) && READY_PATTERN[phase_d];
  end
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state_q <= RECV;
      phase_q <= '0;
      beat_cnt_q <= '0;
      idle_q <= '0;
      ready_q <= 1'b0;
      frame_done_q <= 1'b0;
      early_q <= 1'b0;
      missing_q <= 1'b0;
      timeout_q <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      beat_cnt_q <= beat_cnt_d;
      idle_q <= idle_d;
      ready_q <= ready_d;
      frame_done_q <= frame_done_d;
      early_q <= early_d;
      missing_q <= missing_d;
      timeout_q <= timeout_d;
      rd_data_q <= mem[rd_addr[AW-1:0]];
    end
  end
  // buffer is deliberately unreset so captured data survives a reset
  always_ff @(posedge sclk) begin
    if (take)
      for (int k = 0; k < 8; k++)
        mem[AW'({beat_cnt_q, 3'(k)})] <= leakyrelu_data[8*k +: 8];
  end
  assign ready = ready_q;
  assign rd_data = rd_data_q;
  assign frame_done = frame_done_q;
  assign err_early_last = early_q;
  assign err_missing_last = missing_q;
  assign err_timeout = timeout_q;
  assign beat_cnt = beat_cnt_q;
endmodule

// File: tb/tb_layer0_leakyrelu_rx.sv
// tb_layer0_leakyrelu_rx: two receivers (ready patterns FF and 55) driven by per-instance
// sources, checked every cycle against a frame-level model plus literal expectations.
module tb_layer0_leakyrelu_rx;
  localparam int IE = 32;
  localparam int TO = 64;
  logic sclk = 0, s_rst_n, clr = 0;
  logic [7:0] rd_addr = 0;
  logic vld[2], lst[2];
  logic [63:0] dat[2];
  logic rdy[2], fd[2], ee[2], em[2], et[2];
  logic [5:0] bc[2];
  logic [7:0] rdd[2];
  logic [7:0] pat[2];
  always #5 sclk = ~sclk;
  layer0_leakyrelu_rx dut0 (
    .sclk(sclk), .s_rst_n(s_rst_n), .leakyrelu_data(dat[0]), .leakyrelu_valid(vld[0]),
    .leakyrelu_last(lst[0]), .ready(rdy[0]), .clr(clr), .rd_addr(rd_addr), .rd_data(rdd[0]),
    .frame_done(fd[0]), .err_early_last(ee[0]), .err_missing_last(em[0]),
    .err_timeout(et[0]), .beat_cnt(bc[0]));
  layer0_leakyrelu_rx #(.READY_PATTERN(8'h55)) dut1 (
    .sclk(sclk), .s_rst_n(s_rst_n), .leakyrelu_data(dat[1]), .leakyrelu_valid(vld[1]),
    .leakyrelu_last(lst[1]), .ready(rdy[1]), .clr(clr), .rd_addr(rd_addr), .rd_data(rdd[1]),
    .frame_done(fd[1]), .err_early_last(ee[1]), .err_missing_last(em[1]),
    .err_timeout(et[1]), .beat_cnt(bc[1]));
  int vectors = 0, errors = 0;
  bit m_run[2], m_ready[2], m_fd[2], m_ee[2], m_em[2], m_et[2];
  int m_t[2], m_cnt[2], m_idle[2], src[2], rd_e[2];
  int mbuf[2][256];
  int last_at = 31, stop_at = 99, done1;
  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic drive();
    for (int i = 0; i < 2; i++) begin
      vld[i] = src[i] < stop_at;
      lst[i] = src[i] == last_at;
      for (int k = 0; k < 8; k++) dat[i][8*k +: 8] = 8'(src[i] * 8 + k);
    end
  endtask
  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_run[i] = 1; m_ready[i] = 0; m_t[i] = 0; m_cnt[i] = 0; m_idle[i] = 0; src[i] = 0;
      m_fd[i] = 0; m_ee[i] = 0; m_em[i] = 0; m_et[i] = 0; rd_e[i] = 0;
    end
  endtask
  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      bit acc, end_pos;
      rd_e[i] = mbuf[i][rd_addr];
      acc = vld[i] && m_ready[i] && !clr && m_run[i];
      if (clr) begin
        m_run[i] = 1; m_t[i] = 0; m_cnt[i] = 0; m_idle[i] = 0; src[i] = 0;
        m_fd[i] = 0; m_ee[i] = 0; m_em[i] = 0; m_et[i] = 0;
      end else if (m_run[i]) begin
        m_t[i]++;
        if (acc) begin
          for (int k = 0; k < 8; k++) mbuf[i][m_cnt[i] * 8 + k] = int'(dat[i][8*k +: 8]);
          end_pos = m_cnt[i] == IE - 1;
          if (lst[i] && end_pos) m_fd[i] = 1;
          else if (lst[i]) m_ee[i] = 1;
          else if (end_pos) m_em[i] = 1;
          if (lst[i] || end_pos) m_run[i] = 0;
          m_cnt[i]++; m_idle[i] = 0; src[i]++;
        end else if (m_cnt[i] > 0) begin
          m_idle[i]++;
          if (m_idle[i] == TO) begin m_et[i] = 1; m_run[i] = 0; end
        end
      end
      m_ready[i] = m_run[i] && pat[i][m_t[i] % 8];
    end
  endtask
  task automatic step();
    drive();
    model_edge();
    @(posedge sclk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("ready[%0d]", i), rdy[i], m_ready[i]);
      chk($sformatf("beat_cnt[%0d]", i), bc[i], m_cnt[i]);
      chk($sformatf("frame_done[%0d]", i), fd[i], m_fd[i]);
      chk($sformatf("early[%0d]", i), ee[i], m_ee[i]);
      chk($sformatf("missing[%0d]", i), em[i], m_em[i]);
      chk($sformatf("timeout[%0d]", i), et[i], m_et[i]);
      if (rd_e[i] >= 0) chk($sformatf("rd_data[%0d]", i), rdd[i], rd_e[i]);
    end
  endtask
  task automatic chk_zero(string tag);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s_ready[%0d]", tag, i), rdy[i], 0);
      chk($sformatf("%s_rd_data[%0d]", tag, i), rdd[i], 0);
      chk($sformatf("%s_beat_cnt[%0d]", tag, i), bc[i], 0);
      chk($sformatf("%s_flags[%0d]", tag, i), {fd[i], ee[i], em[i], et[i]}, 0);
    end
  endtask
  task automatic do_reset();
    s_rst_n = 0;
    #1;
    chk_zero("rst_async");
    model_reset();
    repeat (2) @(posedge sclk);
    #1;
    chk_zero("rst_hold");
    s_rst_n = 1;
  endtask
  task automatic pulse_clr();
    clr = 1;
    step();
    clr = 0;
  endtask
  initial begin
    int addrs[5] = '{0, 1, 8, 100, 255};
    pat[0] = 8'hFF;
    pat[1] = 8'h55;
    for (int i = 0; i < 2; i++) for (int a = 0; a < 256; a++) mbuf[i][a] = -1;
    s_rst_n = 1;
    model_reset();
    drive();
    #2;
    do_reset();
    // clean frame on both instances; the 55 pattern takes one beat every other cycle
    pulse_clr();
    done1 = -1;
    for (int s = 1; s <= 80; s++) begin
      step();
      if (fd[1] === 1'b1 && done1 < 0) done1 = s;
    end
    chk("A_done0", fd[0], 1);
    chk("A_cnt0", bc[0], 32);
    chk("A_ready0", rdy[0], 0);
    chk("A_done1", fd[1], 1);
    chk("A_cnt1", bc[1], 32);
    chk("A_err1", {ee[1], em[1], et[1]}, 0);
    chk("A_done1_cycle", done1, 63);
    foreach (addrs[j]) begin
      rd_addr = 8'(addrs[j]);
      step();
      chk("A_rd0", rdd[0], addrs[j]);
      chk("A_rd1", rdd[1], addrs[j]);
    end
    rd_addr = 0;
    last_at = 9;
    pulse_clr();
    repeat (40) step();
    chk("B_early0", ee[0], 1);
    chk("B_cnt0", bc[0], 10);
    chk("B_done0", fd[0], 0);
    chk("B_early1", ee[1], 1);
    chk("B_cnt1", bc[1], 10);
    last_at = -1;
    pulse_clr();
    repeat (80) step();
    chk("C_missing0", em[0], 1);
    chk("C_cnt0", bc[0], 32);
    chk("C_missing1", em[1], 1);
    chk("C_cnt1", bc[1], 32);
    stop_at = 31;
    pulse_clr();
    repeat (140) step();
    chk("D_timeout0", et[0], 1);
    chk("D_cnt0", bc[0], 31);
    chk("D_missing0", em[0], 0);
    chk("D_timeout1", et[1], 1);
    chk("D_cnt1", bc[1], 31);
    last_at = 31;
    stop_at = 12;
    pulse_clr();
    repeat (14) step();
    chk("E_cnt0_pre", bc[0], 12);
    do_reset();
    stop_at = 99;
    pulse_clr();
    repeat (80) step();
    chk("E_done0", fd[0], 1);
    chk("E_cnt0", bc[0], 32);
    chk("E_done1", fd[1], 1);
    chk("E_err1", {ee[1], em[1], et[1]}, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
